// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clkdiv_pkg;

  localparam int unsigned DIV_MIN   = 2;
  localparam int unsigned DEF_WIDTH = 28;
  localparam logic [27:0] DEF_DIV   = 28'd8000000;
  localparam logic [27:0] DEF_HIGH  = 28'd4000000;

  function automatic int ch_lsb(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: period counter, shadow/active configuration and the
// wrap-aligned apply logic that keeps reconfiguration glitch-free.
module clock_divider_channel
  import clkdiv_pkg::*;
#(
  parameter int unsigned      WIDTH        = DEF_WIDTH,
  parameter logic [WIDTH-1:0] DEFAULT_DIV  = WIDTH'(DEF_DIV),
  parameter logic [WIDTH-1:0] DEFAULT_HIGH = WIDTH'(DEF_HIGH)
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] div_cfg,
  input  logic [WIDTH-1:0] high_cfg,
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);

  localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(DIV_MIN);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO    = WIDTH'(0);

  logic [WIDTH-1:0] cnt_r, act_div_r, act_high_r, shd_div_r, shd_high_r;
  logic             run_r, clk_out_r, tick_r, pending_r;

  logic [WIDTH-1:0] eff_div_s, cnt_next_s, nxt_div_s, nxt_high_s;
  logic             wrap_s, apply_s, pending_next_s;

  // Next count, apply decision and the configuration in force after this edge.
  always_comb begin
    eff_div_s      = act_div_r;
    wrap_s         = 1'b0;
    apply_s        = 1'b0;
    cnt_next_s     = ZERO;
    nxt_div_s      = act_div_r;
    nxt_high_s     = act_high_r;
    pending_next_s = pending_r;

    if (act_div_r < MIN_DIV) begin
      eff_div_s = MIN_DIV;
    end else begin
      eff_div_s = act_div_r;
    end

    wrap_s  = en && (cnt_r == (eff_div_s - ONE));
    apply_s = !en || wrap_s;

    // A load on an apply edge bypasses the shadow and takes effect at once.
    if (apply_s) begin
      if (load) begin
        nxt_div_s  = div_cfg;
        nxt_high_s = high_cfg;
      end else begin
        nxt_div_s  = shd_div_r;
        nxt_high_s = shd_high_r;
      end
      pending_next_s = 1'b0;
    end else if (load) begin
      pending_next_s = 1'b1;
    end else begin
      pending_next_s = pending_r;
    end

    // First enabled edge after idle restarts the period at zero.
    if (!en || !run_r || wrap_s) begin
      cnt_next_s = ZERO;
    end else begin
      cnt_next_s = cnt_r + ONE;
    end
  end

  // Channel state and registered outputs.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= ZERO;
      run_r      <= 1'b0;
      clk_out_r  <= 1'b0;
      tick_r     <= 1'b0;
      pending_r  <= 1'b0;
      act_div_r  <= DEFAULT_DIV;
      act_high_r <= DEFAULT_HIGH;
      shd_div_r  <= DEFAULT_DIV;
      shd_high_r <= DEFAULT_HIGH;
    end else begin
      cnt_r      <= cnt_next_s;
      run_r      <= en;
      clk_out_r  <= en && (cnt_next_s < nxt_high_s);
      tick_r     <= en && (cnt_next_s == ZERO);
      pending_r  <= pending_next_s;
      act_div_r  <= nxt_div_s;
      act_high_r <= nxt_high_s;
      if (load) begin
        shd_div_r  <= div_cfg;
        shd_high_r <= high_cfg;
      end else begin
        shd_div_r  <= shd_div_r;
        shd_high_r <= shd_high_r;
      end
    end
  end

  assign clk_out = clk_out_r;
  assign tick    = tick_r;
  assign pending = pending_r;

endmodule

// File: rtl/multi_clock_divider.sv
// NCH independent programmable dividers sharing clk_in; this level only
// slices the packed configuration buses onto per-channel instances.
module multi_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int unsigned      NCH          = 4,
  parameter int unsigned      WIDTH        = DEF_WIDTH,
  parameter logic [WIDTH-1:0] DEFAULT_DIV  = WIDTH'(DEF_DIV),
  parameter logic [WIDTH-1:0] DEFAULT_HIGH = WIDTH'(DEF_HIGH)
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       en,
  input  logic [NCH-1:0]       load,
  input  logic [NCH*WIDTH-1:0] div_cfg,
  input  logic [NCH*WIDTH-1:0] high_cfg,
  output logic [NCH-1:0]       clk_out,
  output logic [NCH-1:0]       tick,
  output logic [NCH-1:0]       pending
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    clock_divider_channel #(
      .WIDTH        (WIDTH),
      .DEFAULT_DIV  (DEFAULT_DIV),
      .DEFAULT_HIGH (DEFAULT_HIGH)
    ) u_ch (
      .clk_in   (clk_in),
      .rst_n    (rst_n),
      .en       (en[i]),
      .load     (load[i]),
      .div_cfg  (div_cfg[ch_lsb(i, WIDTH) +: WIDTH]),
      .high_cfg (high_cfg[ch_lsb(i, WIDTH) +: WIDTH]),
      .clk_out  (clk_out[i]),
      .tick     (tick[i]),
      .pending  (pending[i])
    );
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed bench for multi_clock_divider: periods, duty, apply timing,
// async reset and cross-channel independence (defaults shrunk to 12/6).
module tb_multi_clock_divider;

  localparam int NCH = 4;
  localparam int W   = 28;

  logic               clk_in = 1'b0;
  logic               rst_n;
  logic [NCH-1:0]     en, load;
  logic [NCH*W-1:0]   div_cfg, high_cfg;
  logic [NCH-1:0]     clk_out, tick, pending;

  int tests = 0;
  int fails = 0;

  multi_clock_divider #(
    .NCH          (NCH),
    .WIDTH        (W),
    .DEFAULT_DIV  (28'd12),
    .DEFAULT_HIGH (28'd6)
  ) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .en       (en),
    .load     (load),
    .div_cfg  (div_cfg),
    .high_cfg (high_cfg),
    .clk_out  (clk_out),
    .tick     (tick),
    .pending  (pending)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input int ch, input int d, input int h);
    div_cfg[ch*W +: W]  = W'(d);
    high_cfg[ch*W +: W] = W'(h);
  endtask

  // Disable, load while idle (applies immediately), re-enable: lands on a tick.
  task automatic cfg_en0(input int ch, input int d, input int h, input string tag);
    en[ch] = 1'b0;
    step();
    set_cfg(ch, d, h);
    load[ch] = 1'b1;
    step();
    load[ch] = 1'b0;
    check({tag, "_pend_idle"}, 32'(pending[ch]), 32'd0);
    en[ch] = 1'b1;
    step();
    check({tag, "_tick_first"}, 32'(tick[ch]), 32'd1);
    check({tag, "_clk_first"}, 32'(clk_out[ch]), (h > 0) ? 32'd1 : 32'd0);
  endtask

  // Measure one full period (tick to tick) and its high cycles.
  task automatic measure(input int ch, input int exp_p, input int exp_h, input string tag);
    int w, n, h;
    w = 0;
    while (!tick[ch] && w < 64) begin
      step();
      w++;
    end
    check({tag, "_sync"}, 32'(tick[ch]), 32'd1);
    n = 0;
    h = 0;
    do begin
      if (clk_out[ch]) h++;
      n++;
      step();
    end while (!tick[ch] && n < 64);
    check({tag, "_period"}, 32'(n), 32'(exp_p));
    check({tag, "_high"}, 32'(h), 32'(exp_h));
  endtask

  initial begin
    int dv[NCH];
    int hv[NCH];
    logic [NCH-1:0] tick_e, clk_e;

    rst_n    = 1'b0;
    en       = '0;
    load     = '0;
    div_cfg  = '0;
    high_cfg = '0;
    step();
    step();
    @(negedge clk_in);
    rst_n = 1'b1;
    step();
    check("rst_clk_out", 32'(clk_out), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);

    // 1: DIV=10 HIGH=5
    cfg_en0(0, 10, 5, "t1");
    measure(0, 10, 5, "t1");

    // 2: divisors 0 and 1 clamp to period 2
    cfg_en0(0, 0, 1, "t2a");
    step();
    check("t2a_clk_low", 32'(clk_out[0]), 32'd0);
    check("t2a_tick_low", 32'(tick[0]), 32'd0);
    step();
    check("t2a_clk_hi", 32'(clk_out[0]), 32'd1);
    measure(0, 2, 1, "t2a");
    cfg_en0(0, 1, 1, "t2b");
    measure(0, 2, 1, "t2b");

    // 3: reload mid-period waits for wrap
    cfg_en0(0, 8, 4, "t3");
    step();
    step();
    step();
    set_cfg(0, 4, 2);
    load[0] = 1'b1;
    step();
    load[0] = 1'b0;
    check("t3_pend_set", 32'(pending[0]), 32'd1);
    step();
    step();
    step();
    check("t3_pend_cnt7", 32'(pending[0]), 32'd1);
    check("t3_tick_cnt7", 32'(tick[0]), 32'd0);
    step();
    check("t3_pend_clr", 32'(pending[0]), 32'd0);
    check("t3_tick_wrap", 32'(tick[0]), 32'd1);
    measure(0, 4, 2, "t3_new");

    // 4: load exactly at cnt=D-1 applies on the same edge
    step();
    step();
    step();
    set_cfg(0, 6, 3);
    load[0] = 1'b1;
    step();
    load[0] = 1'b0;
    check("t4_pend_never", 32'(pending[0]), 32'd0);
    check("t4_tick", 32'(tick[0]), 32'd1);
    measure(0, 6, 3, "t4_wrap");
    cfg_en0(0, 4, 1, "t4_idle");
    measure(0, 4, 1, "t4_idle");

    // 5: high=0 and high>=D
    cfg_en0(0, 10, 0, "t5a");
    measure(0, 10, 0, "t5a");
    cfg_en0(0, 10, 12, "t5b");
    measure(0, 10, 10, "t5b");

    // 6: async reset with a pending config discards it
    cfg_en0(0, 10, 5, "t6");
    step();
    step();
    set_cfg(0, 4, 2);
    load[0] = 1'b1;
    step();
    load[0] = 1'b0;
    check("t6_pend", 32'(pending[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_clk", 32'(clk_out), 32'd0);
    check("t6_async_tick", 32'(tick), 32'd0);
    check("t6_async_pend", 32'(pending), 32'd0);
    @(negedge clk_in);
    rst_n = 1'b1;
    step();
    check("t6_tick_after", 32'(tick[0]), 32'd1);
    measure(0, 12, 6, "t6_default");

    // 7: four channels loaded together, checked cycle by cycle
    dv = '{2, 3, 7, 10};
    hv = '{1, 1, 3, 5};
    en = '0;
    step();
    for (int c = 0; c < NCH; c++) set_cfg(c, dv[c], hv[c]);
    load = 4'hF;
    step();
    load = 4'h0;
    check("t7_pend", 32'(pending), 32'd0);
    en = 4'hF;
    step();
    for (int k = 0; k < 30; k++) begin
      for (int c = 0; c < NCH; c++) begin
        tick_e[c] = ((k % dv[c]) == 0);
        clk_e[c]  = ((k % dv[c]) < hv[c]);
      end
      check($sformatf("t7_tick_k%0d", k), 32'(tick), 32'(tick_e));
      check($sformatf("t7_clk_k%0d", k), 32'(clk_out), 32'(clk_e));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
